// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle RV32I core: drives datapath enables,
// mux selects and the unified memory handshake, and counts retired instructions.
//
// state    | meaning
// IDLE     | post-reset, all controls off
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | ALUOut <= OldPC+imm, dispatch on fmt
// MEMADR   | ALUOut <= rs1+imm for load/store
// MEMRD    | load access, wait for mem_ready
// MEMWB    | rd <= read data
// MEMWR    | store access, wait for mem_ready
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// ALUWB    | rd <= ALUOut
// JALR_ADR | ALUOut <= rs1+imm
// JUMP     | PC <= ALUOut, ALUOut <= OldPC+4
// BRANCH   | compare, PC <= target when taken
// UPPER    | lui/auipc sum
// HALT     | ecall/ebreak, stuck until reset
// ERROR    | undefined fmt, stuck until reset
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       fmt,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_valid,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_use_dec,
  output logic [1:0]       result_src,
  output logic             halt,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALUWB    = 4'd9,
    S_JALR_ADR = 4'd10,
    S_JUMP     = 4'd11,
    S_BRANCH   = 4'd12,
    S_UPPER    = 4'd13,
    S_HALT     = 4'd14,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [3:0] F_R  = 4'd0;
  localparam logic [3:0] F_I  = 4'd1;
  localparam logic [3:0] F_IL = 4'd2;
  localparam logic [3:0] F_IE = 4'd3;
  localparam logic [3:0] F_S  = 4'd4;
  localparam logic [3:0] F_B  = 4'd5;
  localparam logic [3:0] F_J  = 4'd6;
  localparam logic [3:0] F_JI = 4'd7;
  localparam logic [3:0] F_U  = 4'd8;
  localparam logic [3:0] F_UP = 4'd9;

  state_t state_q, state_d;
  logic   retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    mem_valid   = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_use_dec = 1'b0;
    result_src  = 2'd0;
    halt        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_valid  = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        case (fmt)
          F_R:        state_d = S_EXEC_R;
          F_I:        state_d = S_EXEC_I;
          F_IL, F_S:  state_d = S_MEMADR;
          F_B:        state_d = S_BRANCH;
          F_J:        state_d = S_JUMP;
          F_JI:       state_d = S_JALR_ADR;
          F_U, F_UP:  state_d = S_UPPER;
          F_IE:       state_d = S_HALT;
          default:    state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        state_d   = (fmt == F_S) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_valid = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a   = 2'd2;
        alu_use_dec = 1'b1;
        state_d     = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd1;
        alu_use_dec = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JALR_ADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        state_d   = S_JUMP;
      end
      S_JUMP: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = 2'd2;
        alu_use_dec = 1'b1;
        pc_write    = branch_taken;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_UPPER: begin
        // lui adds imm to zero, auipc to the instruction's own PC
        alu_src_a = (fmt == F_U) ? 2'd3 : 2'd1;
        alu_src_b = 2'd1;
        state_d   = S_ALUWB;
      end
      S_HALT:  halt    = 1'b1;
      S_ERROR: illegal = 1'b1;
      default: state_d = S_ERROR;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver builds per-instruction cycle
// traces from the instruction-class sequences, a monitor compares each cycle.
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       fmt = 4'd0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_valid, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, result_src;
  logic             alu_use_dec, halt, illegal;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fmt(fmt), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_use_dec(alu_use_dec), .result_src(result_src), .halt(halt),
    .illegal(illegal), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [12:0]      ctl;
    logic             hlt;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             expq[$];
  exp_t             mon_e;
  int               tests = 0;
  int               fails = 0;
  logic [CNT_W-1:0] cnt_m = '0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (expq.size() != 0) begin
      mon_e = expq.pop_front();
      chk("state", 16'(state), 16'(mon_e.st));
      chk("controls", 16'({mem_valid, mem_we, adr_src, ir_write, pc_write, reg_write,
                           alu_src_a, alu_src_b, alu_use_dec, result_src}), 16'(mon_e.ctl));
      chk("halt", 16'(halt), 16'(mon_e.hlt));
      chk("illegal", 16'(illegal), 16'(mon_e.ill));
      chk("instret", 16'(instret), 16'(mon_e.cnt));
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // control word order: mv mwe adr irw pcw rw a b dec rs
  function automatic logic [12:0] c(input logic mv, input logic mwe, input logic adr,
                                    input logic irw, input logic pcw, input logic rw,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic dec, input logic [1:0] rs);
    return {mv, mwe, adr, irw, pcw, rw, a, b, dec, rs};
  endfunction

  task automatic emit(input logic [3:0] st, input logic [12:0] ctl, input logic [3:0] f,
                      input logic rdy, input logic tk, input logic rst);
    exp_t e;
    @(negedge clk);
    fmt = f; mem_ready = rdy; branch_taken = tk; reset = rst;
    e.st = st; e.ctl = ctl; e.hlt = (st == 4'd14); e.ill = (st == 4'd15); e.cnt = cnt_m;
    expq.push_back(e);
  endtask

  // n more cycles with reset held (already in IDLE), then one released IDLE cycle
  task automatic reset_tail(input int n);
    cnt_m = '0;
    for (int i = 0; i < n; i++) emit(4'd0, 13'd0, 4'($urandom), rb(), rb(), 1'b1);
    emit(4'd0, 13'd0, 4'($urandom), rb(), rb(), 1'b0);
  endtask

  task automatic aluwb(input logic [3:0] f);
    emit(4'd9, c(0,0,0,0,0,1,2'd0,2'd0,0,2'd0), f, rb(), rb(), 1'b0);
    cnt_m++;
  endtask

  // wm: memory wait cycles, or stuck-state length for HALT/ERROR
  task automatic run_instr(input logic [3:0] f, input int wf, input int wm,
                           input logic tk, input bit abort_wr);
    for (int i = 0; i < wf; i++) emit(4'd1, c(1,0,0,0,0,0,2'd0,2'd2,0,2'd2), f, 1'b0, rb(), 1'b0);
    emit(4'd1, c(1,0,0,1,1,0,2'd0,2'd2,0,2'd2), f, 1'b1, rb(), 1'b0);
    emit(4'd2, c(0,0,0,0,0,0,2'd1,2'd1,0,2'd0), f, rb(), rb(), 1'b0);
    case (f)
      4'd0: begin emit(4'd7, c(0,0,0,0,0,0,2'd2,2'd0,1,2'd0), f, rb(), rb(), 1'b0); aluwb(f); end
      4'd1: begin emit(4'd8, c(0,0,0,0,0,0,2'd2,2'd1,1,2'd0), f, rb(), rb(), 1'b0); aluwb(f); end
      4'd2: begin
        emit(4'd3, c(0,0,0,0,0,0,2'd2,2'd1,0,2'd0), f, rb(), rb(), 1'b0);
        for (int i = 0; i < wm; i++) emit(4'd4, c(1,0,1,0,0,0,2'd0,2'd0,0,2'd0), f, 1'b0, rb(), 1'b0);
        emit(4'd4, c(1,0,1,0,0,0,2'd0,2'd0,0,2'd0), f, 1'b1, rb(), 1'b0);
        emit(4'd5, c(0,0,0,0,0,1,2'd0,2'd0,0,2'd1), f, rb(), rb(), 1'b0);
        cnt_m++;
      end
      4'd4: begin
        emit(4'd3, c(0,0,0,0,0,0,2'd2,2'd1,0,2'd0), f, rb(), rb(), 1'b0);
        for (int i = 0; i < wm; i++) emit(4'd6, c(1,1,1,0,0,0,2'd0,2'd0,0,2'd0), f, 1'b0, rb(), 1'b0);
        if (abort_wr) begin
          emit(4'd6, c(1,1,1,0,0,0,2'd0,2'd0,0,2'd0), f, rb(), rb(), 1'b1);
          reset_tail(0);
        end else begin
          emit(4'd6, c(1,1,1,0,0,0,2'd0,2'd0,0,2'd0), f, 1'b1, rb(), 1'b0);
          cnt_m++;
        end
      end
      4'd5: begin
        emit(4'd12, c(0,0,0,0,tk,0,2'd2,2'd0,1,2'd0), f, rb(), tk, 1'b0);
        cnt_m++;
      end
      4'd6: begin emit(4'd11, c(0,0,0,0,1,0,2'd1,2'd2,0,2'd0), f, rb(), rb(), 1'b0); aluwb(f); end
      4'd7: begin
        emit(4'd10, c(0,0,0,0,0,0,2'd2,2'd1,0,2'd0), f, rb(), rb(), 1'b0);
        emit(4'd11, c(0,0,0,0,1,0,2'd1,2'd2,0,2'd0), f, rb(), rb(), 1'b0);
        aluwb(f);
      end
      4'd8: begin emit(4'd13, c(0,0,0,0,0,0,2'd3,2'd1,0,2'd0), f, rb(), rb(), 1'b0); aluwb(f); end
      4'd9: begin emit(4'd13, c(0,0,0,0,0,0,2'd1,2'd1,0,2'd0), f, rb(), rb(), 1'b0); aluwb(f); end
      default: begin
        // HALT for ecall/ebreak, ERROR otherwise; inputs wander to prove stickiness
        for (int i = 0; i < wm; i++)
          emit((f == 4'd3) ? 4'd14 : 4'd15, 13'd0, 4'($urandom), rb(), rb(), 1'b0);
        emit((f == 4'd3) ? 4'd14 : 4'd15, 13'd0, 4'($urandom), rb(), rb(), 1'b1);
        reset_tail(1);
      end
    endcase
  endtask

  initial begin
    logic [3:0] f;
    reset_tail(2);
    run_instr(4'd0, 0, 0, 1'b0, 1'b0);
    run_instr(4'd2, 0, 3, 1'b0, 1'b0);
    run_instr(4'd5, 0, 0, 1'b1, 1'b0);
    run_instr(4'd5, 1, 0, 1'b0, 1'b0);
    run_instr(4'd7, 0, 0, 1'b0, 1'b0);
    run_instr(4'd6, 2, 0, 1'b0, 1'b0);
    run_instr(4'd8, 0, 0, 1'b0, 1'b0);
    run_instr(4'd9, 0, 0, 1'b0, 1'b0);
    run_instr(4'd1, 0, 0, 1'b0, 1'b0);
    run_instr(4'd4, 0, 2, 1'b0, 1'b0);
    run_instr(4'd3, 0, 20, 1'b0, 1'b0);
    run_instr(4'd12, 0, 5, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) run_instr(4'd0, 0, 0, 1'b0, 1'b0);
    run_instr(4'd4, 0, 2, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) f = ($urandom_range(0, 1) != 0) ? 4'd3 : 4'($urandom_range(10, 15));
      else begin
        f = 4'($urandom_range(0, 8));
        if (f == 4'd3) f = 4'd9;
      end
      run_instr(f, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 3), rb(), ($urandom_range(0, 15) == 0));
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 16'(expq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM of the multicycle RV32I core; sequences fetch, decode, execute, memory and writeback over the shared ALU, PC, IR and register file.
- Takes the decoded `fmt` class (same encoding the ALU decoder uses) plus the branch compare result, and produces per-cycle datapath enables and mux selects.
- Handshakes with the unified instruction/data memory port and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter `instret`

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high reset
fmt  in  4  instruction class: 0 R, 1 I, 2 IL, 3 IE, 4 S, 5 B, 6 J, 7 JI, 8 U, 9 UP; 10-15 undefined
branch_taken  in  1  ALU compare result for current B-type ALU_ctr
mem_ready  in  1  memory completes current access this cycle
mem_valid  out  1  memory access request
mem_we  out  1  request is a store
adr_src  out  1  memory address: 0 PC, 1 ALUOut register
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from result bus
reg_write  out  1  write rd from result bus
alu_src_a  out  2  0 PC, 1 OldPC, 2 rs1, 3 zero
alu_src_b  out  2  0 rs2, 1 imm, 2 constant 4
alu_use_dec  out  1  1: ALU op from ALU decoder; 0: force ADD
result_src  out  2  result bus: 0 ALUOut reg, 1 mem read data, 2 ALU result direct
halt  out  1  sticky, core stopped by ecall/ebreak
illegal  out  1  sticky, undefined fmt decoded
instret  out  CNT_W  retired instruction count
state  out  4  current state, debug

Behaviour:
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC_R 7, EXEC_I 8, ALUWB 9, JALR_ADR 10, JUMP 11, BRANCH 12, UPPER 13, HALT 14, ERROR 15.
- Reset: state = IDLE, instret = 0.
  - In IDLE every control output is 0; halt = 0, illegal = 0.
  - Reset has priority in every state, including mid-handshake, HALT and ERROR.
- Default for any signal not listed for a state: 0.
- IDLE: always moves to FETCH next cycle.
- FETCH:
  - Outputs: mem_valid=1, adr_src=0, alu_src_a=0, alu_src_b=2, result_src=2.
  - Holds while mem_ready=0.
  - In the mem_ready=1 cycle: ir_write=1, pc_write=1 (PC <= PC+4), then → DECODE.
  - Min fetch latency 1 cycle.
- DECODE: alu_src_a=1, alu_src_b=1 (ALUOut <= OldPC+imm, branch/jal target). Next state by fmt:
  - R → EXEC_R; I → EXEC_I
  - IL, S → MEMADR
  - B → BRANCH; J → JUMP; JI → JALR_ADR
  - U, UP → UPPER
  - IE → HALT; 10-15 → ERROR
- MEMADR: alu_src_a=2, alu_src_b=1 (ALUOut <= rs1+imm). IL → MEMRD; S → MEMWR.
- MEMRD:
  - Outputs: mem_valid=1, adr_src=1.
  - Holds until mem_ready; the read data register captures in the mem_ready cycle.
  - → MEMWB.
- MEMWB: result_src=1, reg_write=1, → FETCH (retire).
- MEMWR: mem_valid=1, mem_we=1, adr_src=1. Holds until mem_ready, then → FETCH (retire).
- EXEC_R: alu_src_a=2, alu_src_b=0, alu_use_dec=1, → ALUWB.
- EXEC_I: alu_src_a=2, alu_src_b=1, alu_use_dec=1, → ALUWB.
- ALUWB: result_src=0, reg_write=1, → FETCH (retire).
- JALR_ADR: alu_src_a=2, alu_src_b=1, → JUMP (ALUOut <= rs1+imm).
- JUMP: alu_src_a=1, alu_src_b=2, result_src=0, pc_write=1 (PC <= target; ALUOut <= OldPC+4), → ALUWB.
- BRANCH:
  - Outputs: alu_src_a=2, alu_src_b=0, alu_use_dec=1, result_src=0.
  - pc_write = branch_taken (combinational on branch_taken in this state only).
  - → FETCH (retire).
- UPPER: alu_src_a = 3 for U, 1 for UP; alu_src_b=1; → ALUWB.
  - fmt sampled in UPPER; IR stable since FETCH.
- HALT: all controls 0, halt=1, stays until reset. No retire.
- ERROR: all controls 0, illegal=1, stays until reset. No retire.
- Retire: instret += 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH.
  - Wraps modulo 2^CNT_W; no saturation.
- Handshake:
  - mem_valid, mem_we and adr_src stay stable while waiting.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
  - No state ever asserts pc_write and reg_write in the same cycle, except none (JUMP writes PC only).
- Cycle counts with zero-wait memory:
  - R/I/U/UP: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 4
  - jalr: 5

Test Plan:
1. Reset held 3 cycles then released → state IDLE, all outputs 0, instret=0; next cycle FETCH with mem_valid=1, adr_src=0.
2. R-type (fmt=0), mem_ready tied 1 → states 1,2,7,9,1; reg_write=1 only in ALUWB; alu_use_dec=1 only in EXEC_R; instret=1.
3. Load (fmt=2), mem_ready low 3 cycles in MEMRD → state 4 for 4 cycles, mem_valid=1, adr_src=1 throughout; MEMWB with result_src=1, reg_write=1; 8 cycles total.
4. Branch (fmt=5): branch_taken=1 → pc_write=1 in BRANCH; repeat with 0 → pc_write=0; both retire, instret +2.
5. jalr (fmt=7) → states 2,10,11,9; JUMP has pc_write=1, alu_src_a=1, alu_src_b=2; ALUWB has reg_write=1.
6. fmt=3 → HALT, halt=1, stays 20 cycles; fmt=12 after reset → ERROR, illegal=1. Preload instret to 2^CNT_W-1 (CNT_W=4, 15 instructions) plus one more retire → instret wraps to 0. Reset asserted mid-MEMWR wait → IDLE next edge, mem_valid drops.
